// File: rtl/core_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : core_irq_ctrl
// Brief   : CP0-style interrupt controller (Status/Cause/EPC, take/ERET FSM).
//           Optional macro IRQ_SYNC_EN adds a 2-flop irq_lines synchroniser.
// Revision: 1.0 - initial release
// ============================================================================
module core_irq_ctrl (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  irq_lines,
    input  logic [63:0] resume_pc,
    input  logic        resume_valid,
    input  logic        stall,
    input  logic        ERET,
    input  logic        cp0_we,
    input  logic [4:0]  cp0_waddr,
    input  logic [63:0] cp0_wdata,
    input  logic [4:0]  cp0_raddr,
    output logic [63:0] cp0_rdata,
    output logic        TakenInterrupt,
    output logic [63:0] EPC
);

    localparam logic [4:0] c_ADDR_STATUS = 5'd12;
    localparam logic [4:0] c_ADDR_CAUSE  = 5'd13;
    localparam logic [4:0] c_ADDR_EPC    = 5'd14;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HANDLER = 2'd1,
        ST_RETURN  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  mask_q, mask_d;
    logic        ie_q, ie_d;
    logic        exl_q, exl_d;
    logic [7:0]  pending_q, pending_d;
    logic [4:0]  code_q, code_d;
    logic [63:0] epc_q, epc_d;
    logic [7:0]  prev_q;

    logic [7:0]  w_irq_s;
    logic [7:0]  w_rise;
    logic [7:0]  w_clr;
    logic [7:0]  w_active;
    logic [4:0]  w_take_code;
    logic        w_take;
    logic        w_wr_status;
    logic        w_wr_cause;
    logic        w_wr_epc;

`ifdef IRQ_SYNC_EN
    logic [7:0] sync1_q;
    logic [7:0] sync2_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q <= 8'h00;
            sync2_q <= 8'h00;
        end else begin
            sync1_q <= irq_lines;
            sync2_q <= sync1_q;
        end
    end

    assign w_irq_s = sync2_q;
`else
    assign w_irq_s = irq_lines;
`endif

    assign w_rise      = w_irq_s & ~prev_q;
    assign w_wr_status = cp0_we && (cp0_waddr == c_ADDR_STATUS);
    assign w_wr_cause  = cp0_we && (cp0_waddr == c_ADDR_CAUSE);
    assign w_wr_epc    = cp0_we && (cp0_waddr == c_ADDR_EPC);
    assign w_clr       = w_wr_cause ? cp0_wdata[15:8] : 8'h00;
    assign w_active    = pending_q & mask_q;

    // Lowest index wins: scan downward so the last hit is the smallest.
    always_comb begin
        w_take_code = 5'd0;
        for (int i = 7; i >= 0; i--) begin
            if (w_active[i]) begin
                w_take_code = 5'(i);
            end
        end
    end

    assign w_take = (state_q == ST_IDLE) && ie_q && !exl_q && (|w_active)
                    && resume_valid && !stall;

    always_comb begin
        state_d   = state_q;
        mask_d    = mask_q;
        ie_d      = ie_q;
        exl_d     = exl_q;
        code_d    = code_q;
        epc_d     = epc_q;
        pending_d = (pending_q & ~w_clr) | w_rise;

        if (w_wr_status) begin
            mask_d = cp0_wdata[15:8];
            ie_d   = cp0_wdata[0];
            exl_d  = cp0_wdata[1];
        end
        if (w_wr_cause) begin
            code_d = cp0_wdata[6:2];
        end
        if (w_wr_epc) begin
            epc_d = cp0_wdata;
        end

        // FSM updates are applied after cp0 writes so they take priority.
        case (state_q)
            ST_IDLE: begin
                if (w_take) begin
                    state_d = ST_HANDLER;
                    epc_d   = resume_pc;
                    exl_d   = 1'b1;
                    code_d  = w_take_code;
                end
            end
            ST_HANDLER: begin
                if (ERET && !stall) begin
                    exl_d   = 1'b0;
                    state_d = ST_RETURN;
                end
            end
            ST_RETURN: begin
                if (!stall) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            mask_q    <= 8'h00;
            ie_q      <= 1'b0;
            exl_q     <= 1'b0;
            pending_q <= 8'h00;
            code_q    <= 5'd0;
            epc_q     <= 64'd0;
            prev_q    <= 8'h00;
        end else begin
            state_q   <= state_d;
            mask_q    <= mask_d;
            ie_q      <= ie_d;
            exl_q     <= exl_d;
            pending_q <= pending_d;
            code_q    <= code_d;
            epc_q     <= epc_d;
            prev_q    <= w_irq_s;
        end
    end

    always_comb begin
        cp0_rdata = 64'd0;
        case (cp0_raddr)
            c_ADDR_STATUS: cp0_rdata = {48'd0, mask_q, 6'd0, exl_q, ie_q};
            c_ADDR_CAUSE:  cp0_rdata = {48'd0, pending_q, 1'b0, code_q, 2'b00};
            c_ADDR_EPC:    cp0_rdata = epc_q;
            default:       cp0_rdata = 64'd0;
        endcase
    end

    assign TakenInterrupt = w_take;
    assign EPC            = epc_q;

endmodule
`default_nettype wire

// File: doc/core_irq_ctrl.md
CORE_IRQ_CTRL -- requirements
Module: core_irq_ctrl

Interface
REQ-001 SHALL have port clock  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port irq_lines  input  8  external level interrupt lines; bit 0 = highest priority.
REQ-004 SHALL have port resume_pc  input  64  PC of oldest uncommitted instruction; becomes EPC on take.
REQ-005 SHALL have port resume_valid  input  1  resume_pc holds a real instruction, not a bubble.
REQ-006 SHALL have port stall  input  1  pipeline frozen this cycle.
REQ-007 SHALL have port ERET  input  1  ERET decoded in ID.
REQ-008 SHALL have ports cp0_we/cp0_waddr/cp0_wdata  input  1/5/64  MTC0 write port.
REQ-009 SHALL have ports cp0_raddr/cp0_rdata  input/output  5/64  MFC0 read port, combinational.
REQ-010 SHALL have port TakenInterrupt  output  1  take pulse to the next-PC/flush logic.
REQ-011 SHALL have port EPC  output  64  current EPC register value.

Function
REQ-012 SHALL implement Status (addr 12): bits[15:8] mask, bit1 EXL, bit0 IE; other bits read 0.
REQ-013 SHALL implement Cause (addr 13): bits[15:8] pending, bits[6:2] code = index of taken line; other bits read 0.
REQ-014 SHALL implement EPC (addr 14), full 64 bits; unmapped addresses read 0 and ignore writes.
REQ-015 SHALL set pending[i] on a rising edge of the synchronised irq_lines[i]; pending stays set after the line drops.
REQ-016 SHALL clear pending[i] only on a Cause write with cp0_wdata[8+i]=1 (write-1-to-clear); a set and a clear of the same bit in one cycle leave it set.
REQ-017 SHALL run FSM IDLE -> HANDLER -> RETURN -> IDLE.
REQ-018 SHALL assert TakenInterrupt combinationally when state=IDLE, IE=1, EXL=0, |(pending & mask), resume_valid=1, stall=0.
REQ-019 SHALL, on the edge ending a take cycle, load EPC<=resume_pc, set EXL, write Cause.code with the lowest set index of pending & mask, and enter HANDLER.
REQ-020 SHALL deassert TakenInterrupt in HANDLER and RETURN regardless of pending.
REQ-021 SHALL, in HANDLER with ERET=1 and stall=0, clear EXL and enter RETURN.
REQ-022 SHALL remain in RETURN exactly one cycle, then go to IDLE; this guarantees one instruction at EPC before a retake.
REQ-023 SHALL ignore ERET in IDLE and RETURN with no state change.
REQ-024 SHALL give take-cycle updates priority over a same-cycle cp0 write to EPC, Status.EXL or Cause.code; other fields of that write take effect.
REQ-025 SHALL hold all state (FSM, EXL, EPC) while stall=1, except pending capture and cp0 writes.

Reset
REQ-026 SHALL on reset force state=IDLE, IE=0, EXL=0, mask=0, pending=0, code=0, EPC=0, and synchroniser/edge flops=0.
REQ-027 SHALL hold TakenInterrupt=0 during and after reset until software sets IE and mask.
REQ-028 SHALL return to IDLE with pending cleared if reset is asserted in any state, including mid-HANDLER.

Configuration
REQ-029 SHALL use macro IRQ_SYNC_EN: when defined, irq_lines pass a 2-flop synchroniser before edge detect; pending is visible 3 edges after the line rises.
REQ-030 SHALL, when IRQ_SYNC_EN is undefined, edge-detect irq_lines directly; pending is visible 1 edge after the line rises. All other behaviour is identical.

Verification
REQ-031 SHALL cover: Status=0x0101, irq_lines=0x01, resume_pc=0x400100, resume_valid=1 -> TakenInterrupt=1 for one cycle; EPC=0x400100, Cause.code=0, EXL=1.
REQ-032 SHALL cover: pending=0x0A, mask=0x0A -> code=1; second take blocked until ERET, then RETURN, then retake with code=3 after Cause W1C of bit 1.
REQ-033 SHALL cover: take condition true but stall=1 or resume_valid=0 for 3 cycles -> no pulse; pulse on first cycle with both OK.
REQ-034 SHALL cover: take cycle plus cp0 write EPC=0xDEAD -> EPC=resume_pc; a later write in HANDLER -> EPC=0xDEAD, and cp0_rdata at addr 14 reads 0xDEAD.
REQ-035 SHALL cover: reset asserted mid-HANDLER -> IDLE, EPC=0, Status=0, pending=0 immediately (asynchronously).
REQ-036 SHALL cover: irq edge latency measured at 3 edges with IRQ_SYNC_EN and 1 edge without; a 1-cycle irq pulse still latches pending.
